// File: rtl/bp_be_dcache_wbuf_pkg.sv
//------------------------------------------------------------------------------
// Module   : bp_be_dcache_wbuf_pkg
// Purpose  : Shared types and constants for the dcache write-buffer controller.
//            Holds the occupancy state encoding and the entry count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bp_be_dcache_wbuf_pkg;

    // Occupancy states; the encoding equals the number of live entries.
    typedef enum logic [1:0] {
        e_wbuf_empty = 2'd0,
        e_wbuf_one   = 2'd1,
        e_wbuf_two   = 2'd2
    } bp_be_wbuf_state_e;

    localparam int wbuf_els_gp   = 2;
    localparam int wbuf_cnt_w_gp = 2;

endpackage : bp_be_dcache_wbuf_pkg

`default_nettype wire

// File: rtl/bp_be_dcache_wbuf_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : bp_be_dcache_wbuf_ctrl_if
// Purpose  : Handshake and datapath-control bundle of the dcache write-buffer
//            controller.
//            slave  : controller side (takes v_i/yumi_i, drives the rest)
//            master : environment side (pipeline, cache arrays, datapath)
// Signals  : v_i/ready_o     write-in handshake
//            v_o/yumi_i      drain handshake
//            el0_en_o/el1_en_o, mux0_sel_o/mux1_sel_o  datapath controls
//            el0_valid_o/el1_valid_o                   snoop qualifiers
//            num_els_o, empty_o, full_o                occupancy status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bp_be_dcache_wbuf_ctrl_if;
    import bp_be_dcache_wbuf_pkg::*;

    logic                     v_i;
    logic                     ready_o;
    logic                     v_o;
    logic                     yumi_i;
    logic                     el0_en_o;
    logic                     el1_en_o;
    logic                     mux0_sel_o;
    logic                     mux1_sel_o;
    logic                     el0_valid_o;
    logic                     el1_valid_o;
    logic [wbuf_cnt_w_gp-1:0] num_els_o;
    logic                     empty_o;
    logic                     full_o;

    modport slave (
        input  v_i, yumi_i,
        output ready_o, v_o, el0_en_o, el1_en_o, mux0_sel_o, mux1_sel_o,
               el0_valid_o, el1_valid_o, num_els_o, empty_o, full_o
    );

    modport master (
        output v_i, yumi_i,
        input  ready_o, v_o, el0_en_o, el1_en_o, mux0_sel_o, mux1_sel_o,
               el0_valid_o, el1_valid_o, num_els_o, empty_o, full_o
    );

endinterface : bp_be_dcache_wbuf_ctrl_if

`default_nettype wire

// File: rtl/bp_be_dcache_wbuf_ctrl.sv
//------------------------------------------------------------------------------
// Module   : bp_be_dcache_wbuf_ctrl
// Purpose  : Occupancy controller for the 2-entry dcache write buffer.
//            Accepts store-miss writes (valid/ready), drains them to the
//            data/tag arrays (valid/yumi), and drives the entry load enables
//            and mux selects of the neighbouring 2-entry datapath.
//            el1 is the head (drain side), el0 is the tail.
// Ports    : clk_i    clock
//            reset_i  synchronous active-high reset
//            wbuf     bp_be_dcache_wbuf_ctrl_if.slave handshake/control bundle
// Config   : BP_BE_DCACHE_WBUF_BYPASS_EN - when defined, a write arriving at an
//            empty buffer is presented on v_o in the same cycle (data_i
//            bypass). When undefined, every write is registered before drain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_be_dcache_wbuf_ctrl
    import bp_be_dcache_wbuf_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_be_dcache_wbuf_ctrl_if.slave  wbuf
);

    localparam int els_lp   = wbuf_els_gp;
    localparam int cnt_w_lp = wbuf_cnt_w_gp;

    localparam logic [cnt_w_lp-1:0] c_st_empty = e_wbuf_empty;
    localparam logic [cnt_w_lp-1:0] c_st_one   = e_wbuf_one;
    localparam logic [cnt_w_lp-1:0] c_st_two   = cnt_w_lp'(els_lp);

    logic [cnt_w_lp-1:0] r_num_els;
    logic [cnt_w_lp-1:0] w_num_els_nxt;
    logic                w_ready;
    logic                w_enq;
    logic                w_deq;
    logic                w_v_o;
    logic                w_el0_en;
    logic                w_el1_en;
    logic                w_mux0_sel;
    logic                w_mux1_sel;
    logic                w_el0_valid;
    logic                w_el1_valid;

    // Output decode and next-state; every output is forced to its idle value
    // while reset is asserted so no entry is written on a reset cycle.
    always_comb begin
        w_num_els_nxt = r_num_els;
        w_v_o         = 1'b0;
        w_el0_en      = 1'b0;
        w_el1_en      = 1'b0;
        w_mux0_sel    = 1'b0;
        w_mux1_sel    = 1'b0;
        w_el0_valid   = 1'b0;
        w_el1_valid   = 1'b0;

        w_ready = ~reset_i & (r_num_els != c_st_two);
        w_enq   = wbuf.v_i & w_ready;
        w_deq   = wbuf.yumi_i & ~reset_i;

        case (r_num_els)
            c_st_empty: begin
`ifdef BP_BE_DCACHE_WBUF_BYPASS_EN
                // Bypass: data_i goes straight to the arrays; only load the
                // head if the cache does not take it this cycle.
                w_v_o      = wbuf.v_i;
                w_mux1_sel = 1'b0;
                if (w_enq && !w_deq) begin
                    w_el1_en      = 1'b1;
                    w_mux0_sel    = 1'b0;
                    w_num_els_nxt = c_st_one;
                end
`else
                // Registered: nothing is visible to the arrays until loaded.
                w_v_o      = 1'b0;
                w_mux1_sel = 1'b1;
                if (w_enq) begin
                    w_el1_en      = 1'b1;
                    w_mux0_sel    = 1'b0;
                    w_num_els_nxt = c_st_one;
                end
`endif
            end
            c_st_one: begin
                w_v_o       = 1'b1;
                w_mux1_sel  = 1'b1;
                w_el1_valid = 1'b1;
                if (w_enq && w_deq) begin
                    // Head drains while the new write takes its place.
                    w_el1_en   = 1'b1;
                    w_mux0_sel = 1'b0;
                end else if (w_enq) begin
                    w_el0_en      = 1'b1;
                    w_num_els_nxt = c_st_two;
                end else if (w_deq) begin
                    w_num_els_nxt = c_st_empty;
                end
            end
            c_st_two: begin
                w_v_o       = 1'b1;
                w_mux1_sel  = 1'b1;
                w_el0_valid = 1'b1;
                w_el1_valid = 1'b1;
                if (w_deq) begin
                    // Tail shifts into the head slot.
                    w_el1_en      = 1'b1;
                    w_mux0_sel    = 1'b1;
                    w_num_els_nxt = c_st_one;
                end
            end
            default: begin
                w_num_els_nxt = c_st_empty;
            end
        endcase

        if (reset_i) begin
            w_v_o       = 1'b0;
            w_el0_en    = 1'b0;
            w_el1_en    = 1'b0;
            w_mux0_sel  = 1'b0;
            w_mux1_sel  = 1'b0;
            w_el0_valid = 1'b0;
            w_el1_valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_num_els <= c_st_empty;
        end else begin
            r_num_els <= w_num_els_nxt;
        end
    end

    assign wbuf.ready_o     = w_ready;
    assign wbuf.v_o         = w_v_o;
    assign wbuf.el0_en_o    = w_el0_en;
    assign wbuf.el1_en_o    = w_el1_en;
    assign wbuf.mux0_sel_o  = w_mux0_sel;
    assign wbuf.mux1_sel_o  = w_mux1_sel;
    assign wbuf.el0_valid_o = w_el0_valid;
    assign wbuf.el1_valid_o = w_el1_valid;
    assign wbuf.num_els_o   = reset_i ? c_st_empty : r_num_els;
    assign wbuf.empty_o     = (wbuf.num_els_o == c_st_empty);
    assign wbuf.full_o      = (wbuf.num_els_o == c_st_two);

    // Protocol and occupancy checks.
    a_yumi_needs_valid : assert property (
        @(posedge clk_i) disable iff (reset_i) wbuf.yumi_i |-> w_v_o);

    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (reset_i) (r_num_els == c_st_two) |-> !w_enq);

    a_num_els_range : assert property (
        @(posedge clk_i) disable iff (reset_i) r_num_els <= c_st_two);

endmodule : bp_be_dcache_wbuf_ctrl

`default_nettype wire

// File: tb/tb_bp_be_dcache_wbuf_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_bp_be_dcache_wbuf_ctrl
// Purpose  : Self-checking bench for bp_be_dcache_wbuf_ctrl. Models the 2-entry
//            datapath driven by the controller's enables/selects and checks
//            drained data against a FIFO scoreboard plus occupancy outputs
//            against a reference count. Honours BP_BE_DCACHE_WBUF_BYPASS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bp_be_dcache_wbuf_ctrl;

    logic clk;
    logic reset_i;

    bp_be_dcache_wbuf_ctrl_if u_if ();

    bp_be_dcache_wbuf_ctrl u_dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .wbuf    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] data_i;
    logic [7:0] data_cnt;
    logic [7:0] m_el0;
    logic [7:0] m_el1;
    logic [7:0] q[$];
    int         m_cnt;

    // Snapshot of the last cycle's outputs for directed checks.
    logic       s_v_o, s_mux0, s_mux1, s_el0_en, s_el1_en, s_ready;
    logic [7:0] s_data;
    int         s_num;

    // Reference 2-entry datapath wired to the controller.
    always @(posedge clk) begin
        if (u_if.el0_en_o) m_el0 <= data_i;
        if (u_if.el1_en_o) m_el1 <= u_if.mux0_sel_o ? m_el0 : data_i;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic yreq);
        logic       enq;
        logic       deq;
        logic [7:0] drained;
        logic       exp_v_o;
        logic       exp_mux1;
        @(negedge clk);
        u_if.v_i    = v;
        data_i      = data_cnt;
        u_if.yumi_i = 1'b0;
        #1;
        u_if.yumi_i = yreq & u_if.v_o;
        #1;
`ifdef BP_BE_DCACHE_WBUF_BYPASS_EN
        exp_v_o  = (m_cnt != 0) | v;
        exp_mux1 = (m_cnt != 0);
`else
        exp_v_o  = (m_cnt != 0);
        exp_mux1 = 1'b1;
`endif
        s_v_o    = u_if.v_o;
        s_mux0   = u_if.mux0_sel_o;
        s_mux1   = u_if.mux1_sel_o;
        s_el0_en = u_if.el0_en_o;
        s_el1_en = u_if.el1_en_o;
        s_ready  = u_if.ready_o;
        chk("num_els", int'(u_if.num_els_o), m_cnt);
        chk("ready",   int'(u_if.ready_o),   int'(m_cnt != 2));
        chk("v_o",     int'(u_if.v_o),       int'(exp_v_o));
        chk("mux1",    int'(u_if.mux1_sel_o), int'(exp_mux1));
        chk("el1_vld", int'(u_if.el1_valid_o), int'(m_cnt >= 1));
        chk("el0_vld", int'(u_if.el0_valid_o), int'(m_cnt == 2));
        chk("empty",   int'(u_if.empty_o),   int'(m_cnt == 0));
        chk("full",    int'(u_if.full_o),    int'(m_cnt == 2));
        enq = v & u_if.ready_o;
        deq = u_if.yumi_i;
        s_data = data_i;
        if (enq) begin
            q.push_back(data_i);
            data_cnt++;
        end
        if (deq) begin
            drained = u_if.mux1_sel_o ? m_el1 : data_i;
            if (q.size() == 0) chk("underflow", 1, 0);
            else               chk("order", int'(drained), int'(q.pop_front()));
        end
        m_cnt = m_cnt + int'(enq) - int'(deq);
        @(posedge clk);
        #1;
        s_num = int'(u_if.num_els_o);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i     = 1'b1;
        u_if.v_i    = 1'b1;
        u_if.yumi_i = 1'b0;
        #2;
        chk("rst_el0_en", int'(u_if.el0_en_o), 0);
        chk("rst_el1_en", int'(u_if.el1_en_o), 0);
        chk("rst_v_o",    int'(u_if.v_o),      0);
        chk("rst_ready",  int'(u_if.ready_o),  0);
        chk("rst_el_vld", int'(u_if.el0_valid_o | u_if.el1_valid_o), 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        q.delete();
        m_cnt = 0;
        chk("rst_num", int'(u_if.num_els_o), 0);
    endtask

    initial begin
        reset_i     = 1'b1;
        u_if.v_i    = 1'b0;
        u_if.yumi_i = 1'b0;
        data_i      = 8'h00;
        data_cnt    = 8'h10;
        m_cnt       = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // Fill: 1, 2, then a rejected third write.
        cycle(1'b1, 1'b0); chk("fill1_num", s_num, 1);
        cycle(1'b1, 1'b0); chk("fill2_num", s_num, 2);
        cycle(1'b1, 1'b0); chk("fill3_ready", int'(s_ready), 0);
        chk("fill3_num", s_num, 2);

        // Drain A then B; first drain shifts tail to head.
        cycle(1'b0, 1'b1);
        chk("drain1_el1_en", int'(s_el1_en), 1);
        chk("drain1_mux0",   int'(s_mux0), 1);
        cycle(1'b0, 1'b1); chk("drain2_num", s_num, 0);

        // Write and consume together from EMPTY.
        cycle(1'b1, 1'b1);
`ifdef BP_BE_DCACHE_WBUF_BYPASS_EN
        chk("byp_v_o",   int'(s_v_o), 1);
        chk("byp_mux1",  int'(s_mux1), 0);
        chk("byp_en",    int'(s_el0_en | s_el1_en), 0);
        chk("byp_num",   s_num, 0);
`else
        chk("reg_v_o",    int'(s_v_o), 0);
        chk("reg_el1_en", int'(s_el1_en), 1);
        chk("reg_num",    s_num, 1);
        cycle(1'b0, 1'b1); chk("reg_drain_num", s_num, 0);
`endif

        // ONE with simultaneous write and consume.
        cycle(1'b1, 1'b0); chk("one_num", s_num, 1);
        cycle(1'b1, 1'b1);
        chk("repl_el1_en", int'(s_el1_en), 1);
        chk("repl_mux0",   int'(s_mux0), 0);
        chk("repl_num",    s_num, 1);
        chk("repl_head",   int'(m_el1), int'(s_data));
        cycle(1'b0, 1'b1); chk("repl_drain_num", s_num, 0);

        // Reset from FULL.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0); chk("full_num", s_num, 2);
        do_reset();
        cycle(1'b0, 1'b0);
        chk("post_rst_v_o", int'(s_v_o), 0);
        chk("post_rst_num", s_num, 0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        chk("final_num",  s_num, 0);
        chk("final_q",    q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bp_be_dcache_wbuf_ctrl

`default_nettype wire
